// File: rtl/spi_slave_mem_ctrl.sv
// rtl/spi_slave_mem_ctrl.sv - SPI mode-0 slave that turns one CS_N frame into one memory read or write.
// Optional sticky frame error reporting is enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_mem_ctrl #(
  parameter int AWIDTH      = 12,
  parameter int DWIDTH      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int CW = $clog2(AWIDTH + DWIDTH + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_REQ, RD_WAIT, DATA, DONE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
  logic                    sclk_d, cs_d;
  logic                    sclk_s, cs_s, mosi_s;
  logic                    sclk_rise, sclk_fall, cs_fall;
  logic                    op;
  logic                    rd_hold;
  logic [CW-1:0]           cnt;
  logic [AWIDTH-2:0]       addr_sr;
  // Holds received write bits, or the not-yet-sent read bits (MSB already on miso).
  logic [DWIDTH-2:0]       data_sr;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  // Sync flops reset to 0, so a fall can only be seen after cs_n has been observed high.
  assign cs_fall   = ~cs_s & cs_d;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic err_q;
  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sclk_sync  <= '0;
      cs_sync    <= '0;
      mosi_sync  <= '0;
      sclk_d     <= 1'b0;
      cs_d       <= 1'b0;
      op         <= 1'b0;
      rd_hold    <= 1'b0;
      cnt        <= '0;
      addr_sr    <= '0;
      data_sr    <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      frame_done <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d     <= sclk_s;
      cs_d       <= cs_s;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      frame_done <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (sclk_rise && cs_s) err_q <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= CMD;
            cnt   <= '0;
          end
        end
        DONE: begin
          if (cs_s) state <= IDLE;
        end
        default: begin
          if (cs_s) begin
            state   <= IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            err_q   <= 1'b1;
`endif
          end else begin
            case (state)
              CMD: begin
                if (sclk_rise) begin
                  op    <= mosi_s;
                  cnt   <= '0;
                  state <= ADDR;
                end
              end
              ADDR: begin
                if (sclk_rise) begin
                  addr_sr <= {addr_sr[AWIDTH-3:0], mosi_s};
                  cnt     <= cnt + CW'(1);
                  if (cnt == CW'(AWIDTH - 1)) begin
                    mem_addr <= {addr_sr, mosi_s};
                    cnt      <= '0;
                    state    <= op ? DATA : RD_REQ;
                  end
                end
              end
              RD_REQ: begin
                mem_re  <= 1'b1;
                rd_hold <= 1'b0;
                state   <= RD_WAIT;
              end
              RD_WAIT: begin
                // Memory answers one clk after it samples mem_re.
                if (!rd_hold) begin
                  rd_hold <= 1'b1;
                end else begin
                  data_sr <= mem_rdata[DWIDTH-2:0];
                  miso    <= mem_rdata[DWIDTH-1];
                  miso_oe <= 1'b1;
                  state   <= DATA;
                end
              end
              DATA: begin
                if (sclk_rise) begin
                  cnt <= cnt + CW'(1);
                  if (op) data_sr <= {data_sr[DWIDTH-3:0], mosi_s};
                  if (cnt == CW'(DWIDTH - 1)) begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                    miso       <= 1'b0;
                    miso_oe    <= 1'b0;
                    if (op) begin
                      mem_wdata <= {data_sr, mosi_s};
                      mem_we    <= 1'b1;
                    end
                  end
                end else if (sclk_fall && !op && cnt != '0) begin
                  data_sr <= {data_sr[DWIDTH-3:0], 1'b0};
                  miso    <= data_sr[DWIDTH-2];
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_mem_ctrl.sv
// tb/tb_spi_slave_mem_ctrl.sv - randomized scoreboard bench for spi_slave_mem_ctrl.
module tb_spi_slave_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe, mem_we, mem_re, frame_done, frame_err;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;
  int exp_done = 0;
  int done_seen = 0;
  bit exp_err = 1'b0;

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [31:0] data;
  } acc_t;
  acc_t exp_q[$];

  bit [31:0]   mem [0:4095];
  bit [31:0]   ref_mem [0:4095];
  bit          preload_en = 1'b0;
  logic [11:0] preload_addr = '0;
  logic [31:0] preload_data = '0;

  always #5 clk = ~clk;

  spi_slave_mem_ctrl #(.AWIDTH(12), .DWIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always @(posedge clk) begin
    if (preload_en) mem[preload_addr] <= preload_data;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: every memory strobe must match the oldest expected access.
  always @(negedge clk) begin
    if (frame_done) done_seen++;
    if (mem_we || mem_re) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_access we=%0b addr=%0h", mem_we, mem_addr);
      end else begin
        acc_t e;
        e = exp_q.pop_front();
        if (mem_we !== e.we || mem_re !== !e.we || mem_addr !== e.addr ||
            (e.we && mem_wdata !== e.data)) begin
          bad++;
          $display("FAIL access act we=%0b re=%0b addr=%0h wdata=%0h exp we=%0b addr=%0h wdata=%0h",
                   mem_we, mem_re, mem_addr, mem_wdata, e.we, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    ref_mem[a]   = d;
    preload_addr = a;
    preload_data = d;
    preload_en   = 1'b1;
    tick(1);
    preload_en   = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, {miso, miso_oe, mem_addr, mem_wdata, mem_we, mem_re, frame_done, frame_err}, '0);
  endtask

  // Master side of one frame: nbits < 45 aborts, rst_at >= 0 resets mid-frame, extra adds trailing pulses.
  task automatic spi_frame(input bit op, input logic [11:0] addr, input logic [31:0] data,
                           input int nbits, input int half, input int rst_at, input int extra);
    logic [44:0] f;
    logic [31:0] got;
    logic [31:0] exp_rd;
    int          oe_bad;
    bit          reset_hit;
    acc_t        a;
    f = {op, addr, data};
    got = '0;
    oe_bad = 0;
    reset_hit = (rst_at >= 0);
    exp_rd = ref_mem[addr];
    if (!reset_hit) begin
      if (!op && nbits >= 13) begin
        a.we = 1'b0; a.addr = addr; a.data = '0;
        exp_q.push_back(a);
      end
      if (nbits >= 45) begin
        exp_done++;
        if (op) begin
          a.we = 1'b1; a.addr = addr; a.data = data;
          exp_q.push_back(a);
          ref_mem[addr] = data;
        end
      end else begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
        exp_err = 1'b1;
`endif
      end
    end else begin
      exp_err = 1'b0;
    end
    cs_n = 1'b0;
    tick(half);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick(1);
        chk_outputs_zero("reset_mid_frame_outputs");
        rst_n = 1'b1;
      end
      mosi = f[44-i];
      tick(half);
      if (!op && i >= 13) got = {got[30:0], miso};
      if (miso_oe !== (!op && i >= 13 && !reset_hit)) oe_bad++;
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
    end
    for (int k = 0; k < extra; k++) begin
      tick(half);
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
    end
    tick(half);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(8);
    if (!op && nbits >= 45 && !reset_hit) chk("read_word", got, exp_rd);
    chk("miso_oe_phase", oe_bad, 0);
    chk("frame_done_count", done_seen, exp_done);
    chk("pending_accesses", exp_q.size(), 0);
    chk("frame_err", frame_err, exp_err);
    chk("miso_oe_idle", miso_oe, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [11:0] ra;
    tick(4);
    chk_outputs_zero("reset_state");
    rst_n = 1'b1;
    tick(4);
    chk_outputs_zero("post_reset_idle");
    preload(12'h010, 32'h12345678);

    spi_frame(1'b1, 12'h0A4, 32'hDEADBEEF, 45, 8, -1, 0);
    spi_frame(1'b0, 12'h010, 32'h0, 45, 8, -1, 0);
    spi_frame(1'b1, 12'h0B0, 32'hCAFEF00D, 20, 8, -1, 0);
    spi_frame(1'b1, 12'h004, 32'hA5A5A5A5, 45, 8, -1, 0);
    spi_frame(1'b0, 12'h004, 32'h0, 45, 7, -1, 0);
    spi_frame(1'b1, 12'h300, 32'h11112222, 45, 8, 30, 0);
    spi_frame(1'b1, 12'h300, 32'h33334444, 45, 8, -1, 0);
    spi_frame(1'b1, 12'h020, 32'h00000001, 45, 8, -1, 0);
    spi_frame(1'b0, 12'h020, 32'h0, 45, 8, -1, 50);
    spi_frame(1'b0, 12'h300, 32'h0, 45, 6, -1, 0);
    spi_frame(1'b1, 12'h0F0, 32'h80000001, 45, 6, -1, 0);
    spi_frame(1'b0, 12'h0F0, 32'h0, 45, 6, -1, 0);

    for (int n = 0; n < 16; n++) begin
      rd = $urandom;
      ra = 12'($urandom_range(0, 63) * 4);
      spi_frame(1'($urandom_range(0, 1)), ra, rd, 45, $urandom_range(6, 9), -1,
                $urandom_range(0, 3));
    end

    for (int k = 0; k < 3; k++) begin
      tick(7);
      sclk = 1'b1;
      tick(7);
      sclk = 1'b0;
    end
    tick(8);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    exp_err = 1'b1;
`endif
    chk("err_sclk_while_deselected", frame_err, exp_err);
    chk("no_stray_access", exp_q.size(), 0);
    chk("no_stray_done", done_seen, exp_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
